// File: rtl/memory_arbiter.sv
// memory_arbiter: responder side of the cache/memory control interface.
// Arbitrates icache fetch misses and dcache read/write requests onto a
// single RAM port, one access in flight at a time.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner of
// simultaneous requests; otherwise the data side always wins ties.

module memory_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM side
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    // status
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC
    } state_t;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = (TW > 8) ? TW : 8;
    localparam logic [31:0] TIMEOUT_WORD = 32'hBAD1_BAD1;

    state_t          state;
    logic [CW-1:0]   count;

    logic            d_req;
    logic            grant_d;
    logic            grant_i;
    logic            i_active;
    logic            d_active;
    logic            tmo_hit;
    logic            i_done;
    logic            d_done;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side was granted most recently, 0 = instruction side
    logic            last_d;
`endif

    // Request decode, arbitration and completion detection
    always_comb begin
        d_req    = dREN | dWEN;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d  = d_req && (!iREN || !last_d);
`else
        grant_d  = d_req;
`endif
        grant_i  = iREN && !grant_d;
        // A granted side that has dropped its request is treated as aborted
        i_active = (state == IACC) && iREN;
        d_active = (state == DACC) && d_req;
        tmo_hit  = (count == CW'(TIMEOUT)) && !ramready;
        i_done   = i_active && (ramready || tmo_hit);
        d_done   = d_active && (ramready || tmo_hit);
    end

    // Arbiter FSM, access-cycle counter and sticky timeout flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            count       <= '0;
            timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (grant_d) begin
                        state  <= DACC;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d <= 1'b1;
`endif
                    end else if (grant_i) begin
                        state  <= IACC;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d <= 1'b0;
`endif
                    end
                end
                IACC: begin
                    if (!ramready) begin
                        count <= count + 1'b1;
                    end
                    if (!i_active || i_done) begin
                        state <= IDLE;
                    end
                    if (i_done && tmo_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                DACC: begin
                    if (!ramready) begin
                        count <= count + 1'b1;
                    end
                    if (!d_active || d_done) begin
                        state <= IDLE;
                    end
                    if (d_done && tmo_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // RAM strobes and requester responses, combinational so that completion
    // and abort take effect within the current access cycle
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        if (i_active) begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (i_done) begin
                iwait = 1'b0;
                iload = tmo_hit ? TIMEOUT_WORD : ramload;
            end
        end
        if (d_active) begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (d_done) begin
                dwait = 1'b0;
                if (tmo_hit) begin
                    dload = TIMEOUT_WORD;
                end else if (dREN) begin
                    dload = ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed stimulus with a completion scoreboard.
// Stimulus pushes the expected completion; a negedge monitor pops and
// compares whenever iwait or dwait goes low.

module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        timeout_err;

    always #5 CLK = ~CLK;

    memory_arbiter #(.TIMEOUT(4)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iwait       (iwait),
        .iload       (iload),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .dwait       (dwait),
        .dload       (dload),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramready    (ramready),
        .timeout_err (timeout_err)
    );

    typedef struct {
        bit          is_d;
        logic [31:0] load;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_done(input bit is_d, input logic [31:0] load, input logic [31:0] addr);
        exp_t e;
        e.is_d = is_d;
        e.load = load;
        e.addr = addr;
        sb.push_back(e);
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ramREN"},   ramREN,      32'd0);
        chk({tag, "_ramWEN"},   ramWEN,      32'd0);
        chk({tag, "_ramaddr"},  ramaddr,     32'd0);
        chk({tag, "_ramstore"}, ramstore,    32'd0);
        chk({tag, "_iload"},    iload,       32'd0);
        chk({tag, "_dload"},    dload,       32'd0);
        chk({tag, "_iwait"},    iwait,       32'd1);
        chk({tag, "_dwait"},    dwait,       32'd1);
        chk({tag, "_tmo_err"},  timeout_err, 32'd0);
    endtask

    // Monitor: every completion must match the head of the scoreboard
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (!iwait || !dwait) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: iwait=%b dwait=%b expected no completion (t=%0t)",
                             iwait, dwait, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_side", {31'b0, !dwait}, {31'b0, mon_e.is_d});
                    if (mon_e.is_d) begin
                        chk("dload", dload, mon_e.load);
                        chk("dwait_other_iwait", iwait, 32'd1);
                    end else begin
                        chk("iload", iload, mon_e.load);
                        chk("iwait_other_dwait", dwait, 32'd1);
                    end
                    chk("done_ramaddr", ramaddr, mon_e.addr);
                end
            end
            if (iwait) chk("iload_zero", iload, 32'd0);
            if (dwait) chk("dload_zero", dload, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramready = 1'b0;

        // reset state
        #12;
        chk_reset_outputs("rst");
        nRST = 1'b1;
        step();

        // single fetch, ramready one cycle after ramREN
        iREN = 1'b1; iaddr = 32'h40;
        step();                               // IACC cycle 1
        chk("f_ramREN", ramREN, 32'd1);
        chk("f_ramaddr", ramaddr, 32'h40);
        chk("f_iwait_c1", iwait, 32'd1);
        step();                               // IACC cycle 2
        ramready = 1'b1; ramload = 32'h8C22_0004;
        expect_done(1'b0, 32'h8C22_0004, 32'h40);
        #1;
        chk("f_iwait_c2", iwait, 32'd0);
        step();                               // IDLE
        ramready = 1'b0; ramload = '0; iREN = 1'b0;
        #1;
        chk("f_idle_ramREN", ramREN, 32'd0);
        chk("f_idle_iwait", iwait, 32'd1);

        // write, ramready on third access cycle
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        step();                               // DACC cycle 1
        chk("w_ramWEN_c1", ramWEN, 32'd1);
        chk("w_ramREN_c1", ramREN, 32'd0);
        chk("w_ramaddr", ramaddr, 32'h100);
        chk("w_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("w_dwait_c1", dwait, 32'd1);
        step();                               // DACC cycle 2
        chk("w_ramWEN_c2", ramWEN, 32'd1);
        chk("w_dwait_c2", dwait, 32'd1);
        step();                               // DACC cycle 3
        ramready = 1'b1; ramload = 32'h5555_AAAA;
        expect_done(1'b1, 32'h0, 32'h100);
        #1;
        chk("w_ramWEN_c3", ramWEN, 32'd1);
        chk("w_iwait_c3", iwait, 32'd1);
        step();                               // IDLE
        ramready = 1'b0; ramload = '0; dWEN = 1'b0;
        #1;
        chk("w_idle_ramWEN", ramWEN, 32'd0);

        // tie: data first, then instruction once data drops
        iREN = 1'b1; iaddr = 32'h200;
        dREN = 1'b1; daddr = 32'h300;
        step();
        chk("t1_first_addr", ramaddr, 32'h300);
        ramready = 1'b1; ramload = 32'h1111_1111;
        expect_done(1'b1, 32'h1111_1111, 32'h300);
        step();                               // IDLE
        ramready = 1'b0; ramload = '0; dREN = 1'b0;
        #1;
        chk("t1_idle_ramREN", ramREN, 32'd0);
        step();                               // IACC
        chk("t1_second_addr", ramaddr, 32'h200);
        ramready = 1'b1; ramload = 32'h2222_2222;
        expect_done(1'b0, 32'h2222_2222, 32'h200);
        step();
        ramready = 1'b0; ramload = '0; iREN = 1'b0;

        // tie with both held across two grants
        step();
        iREN = 1'b1; iaddr = 32'h200;
        dREN = 1'b1; daddr = 32'h300;
        step();
        chk("t2_first_addr", ramaddr, 32'h300);
        ramready = 1'b1; ramload = 32'h3333_3333;
        expect_done(1'b1, 32'h3333_3333, 32'h300);
        step();                               // IDLE, both still held
        ramready = 1'b0; ramload = '0;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("t2_second_addr", ramaddr, 32'h200);
        ramready = 1'b1; ramload = 32'h4444_4444;
        expect_done(1'b0, 32'h4444_4444, 32'h200);
`else
        chk("t2_second_addr", ramaddr, 32'h300);
        ramready = 1'b1; ramload = 32'h4444_4444;
        expect_done(1'b1, 32'h4444_4444, 32'h300);
`endif
        step();
        ramready = 1'b0; ramload = '0; iREN = 1'b0; dREN = 1'b0;
        step();

        // abort: data drops mid-access, pending fetch granted afterwards
        iREN = 1'b1; iaddr = 32'h500;
        dREN = 1'b1; daddr = 32'h600;
        step();                               // DACC cycle 1
        chk("a_ramREN_c1", ramREN, 32'd1);
        chk("a_ramaddr_c1", ramaddr, 32'h600);
        step();                               // DACC cycle 2, drop request
        dREN = 1'b0;
        #1;
        chk("a_ramREN_drop", ramREN, 32'd0);
        chk("a_dwait_drop", dwait, 32'd1);
        step();                               // IDLE
        chk("a_idle_ramREN", ramREN, 32'd0);
        step();                               // IACC
        chk("a_i_ramREN", ramREN, 32'd1);
        chk("a_i_ramaddr", ramaddr, 32'h500);
        ramready = 1'b1; ramload = 32'h5555_5555;
        expect_done(1'b0, 32'h5555_5555, 32'h500);
        step();
        ramready = 1'b0; ramload = '0; iREN = 1'b0;

        // timeout: no ramready, completion forced in the fifth access cycle
        iREN = 1'b1; iaddr = 32'h700;
        step();                               // cycle 1
        chk("to_err_c1", timeout_err, 32'd0);
        step();                               // cycle 2
        step();                               // cycle 3
        step();                               // cycle 4
        chk("to_iwait_c4", iwait, 32'd1);
        step();                               // cycle 5
        expect_done(1'b0, 32'hBAD1_BAD1, 32'h700);
        chk("to_err_c5", timeout_err, 32'd0);
        chk("to_iwait_c5", iwait, 32'd0);
        step();
        iREN = 1'b0;
        #1;
        chk("to_err_set", timeout_err, 32'd1);
        step();
        step();
        chk("to_err_sticky", timeout_err, 32'd1);

        // reset pulsed during a data write
        dWEN = 1'b1; daddr = 32'h800; dstore = 32'h1234_5678;
        step();                               // DACC cycle 1
        chk("r_ramWEN", ramWEN, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk_reset_outputs("rmid");
        dWEN = 1'b0;
        step();
        nRST = 1'b1;
        dREN = 1'b1; daddr = 32'h900;
        step();                               // DACC
        chk("r_fresh_ramREN", ramREN, 32'd1);
        chk("r_fresh_ramaddr", ramaddr, 32'h900);
        ramready = 1'b1; ramload = 32'h9999_9999;
        expect_done(1'b1, 32'h9999_9999, 32'h900);
        step();
        ramready = 1'b0; ramload = '0; dREN = 1'b0;
        step();
        step();

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
